fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared instruction-bus and fetch-FSM types used by fetch_unit and its bench.
package defs;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] a);
        return (a[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-word instruction fetch over a split address/data handshake bus.
// Optional macro FETCH_ALIGN_CHECK_EN rejects misaligned PCs with a faulted done.
//
//   state | meaning
//   IDLE  | waiting for start; done pulses here
//   ADDR  | request on bus, waiting for addr_ok
//   DATA  | address accepted, waiting for data_ok
//   DRAIN | flushed; waiting for data_ok to discard it
module fetch_unit
    import defs::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic        flush,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    output logic        busy,
    output logic        done,
    output logic [31:0] instr,
    output logic        fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  instr_q, instr_d;
    logic         done_q, done_d;
    logic         flushed_q, flushed_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic         fault_q, fault_d;
`endif

    logic abandon;
    assign abandon = flushed_q | flush;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        flushed_d = flushed_q;
        done_d    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (is_misaligned(pc)) begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        instr_d = RESET_INSTR;
                    end else begin
                        addr_d    = pc;
                        flushed_d = 1'b0;
                        state_d   = ADDR;
                    end
`else
                    addr_d    = pc;
                    flushed_d = 1'b0;
                    state_d   = ADDR;
`endif
                end
            end
            ADDR: begin
                // A flush here cannot retract the request; remember it until addr_ok.
                if (iresp.addr_ok) begin
                    if (iresp.data_ok) begin
                        state_d = IDLE;
                        if (!abandon) begin
                            instr_d = iresp.data;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = abandon ? DRAIN : DATA;
                    end
                    flushed_d = 1'b0;
                end else if (flush) begin
                    flushed_d = 1'b1;
                end
            end
            DATA: begin
                if (iresp.data_ok) begin
                    state_d = IDLE;
                    if (!flush) begin
                        instr_d = iresp.data;
                        done_d  = 1'b1;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (iresp.data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0;
            instr_q   <= RESET_INSTR;
            done_q    <= 1'b0;
            flushed_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            done_q    <= done_d;
            flushed_q <= flushed_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q   <= fault_d;
`endif
        end
    end

    assign ireq.valid = (state_q == ADDR);
    assign ireq.addr  = addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign instr      = instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fault      = fault_q;
`else
    assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, flush, reset abort, alignment.
module tb_fetch_unit;
    import defs::*;

    localparam logic [31:0] RI = 32'hCAFE_0001;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] pc;
    logic        flush;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        busy;
    logic        done;
    logic [31:0] instr;
    logic        fault;

    int n_chk = 0;
    int n_err = 0;

    fetch_unit #(.RESET_INSTR(RI)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .pc     (pc),
        .flush  (flush),
        .ireq   (ireq),
        .iresp  (iresp),
        .busy   (busy),
        .done   (done),
        .instr  (instr),
        .fault  (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are then stable for the cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] d);
        iresp.addr_ok = aok;
        iresp.data_ok = dok;
        iresp.data    = d;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; pc = 32'h0; flush = 1'b0;
        bus(1'b0, 1'b0, 32'h0);
        tick(); tick();
        chk("rst_busy",  {31'h0, busy},       32'h0);
        chk("rst_valid", {31'h0, ireq.valid}, 32'h0);
        chk("rst_done",  {31'h0, done},       32'h0);
        chk("rst_fault", {31'h0, fault},      32'h0);
        chk("rst_instr", instr,               RI);
        resetn = 1'b1;
        tick();

        // Address accepted cycle 1, data in cycle 3, done in cycle 4.
        pc = 32'hBFC0_0000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("a_valid", {31'h0, ireq.valid}, 32'h1);
        chk("a_addr",  ireq.addr,           32'hBFC0_0000);
        chk("a_busy",  {31'h0, busy},       32'h1);
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("a_valid_low", {31'h0, ireq.valid}, 32'h0);
        chk("a_busy2",     {31'h0, busy},       32'h1);
        tick();
        chk("a_nodone3", {31'h0, done}, 32'h0);
        bus(1'b0, 1'b1, 32'h0000_0021);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("a_done",  {31'h0, done},  32'h1);
        chk("a_fault", {31'h0, fault}, 32'h0);
        chk("a_instr", instr,          32'h0000_0021);
        chk("a_idle",  {31'h0, busy},  32'h0);
        tick();
        chk("a_pulse", {31'h0, done}, 32'h0);
        chk("a_hold",  instr,         32'h0000_0021);

        // addr_ok and data_ok together in the first ADDR cycle.
        pc = 32'h0000_1000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_valid", {31'h0, ireq.valid}, 32'h1);
        bus(1'b1, 1'b1, 32'h1000_FFFF);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("b_done",  {31'h0, done}, 32'h1);
        chk("b_busy",  {31'h0, busy}, 32'h0);
        chk("b_instr", instr,         32'h1000_FFFF);

        // Request held stable while addr_ok is withheld; start ignored while busy.
        pc = 32'h0000_2004; start = 1'b1;
        tick();
        pc = 32'h0000_9990;
        for (int i = 0; i < 5; i++) begin
            chk("c_valid", {31'h0, ireq.valid}, 32'h1);
            chk("c_addr",  ireq.addr,           32'h0000_2004);
            chk("c_done",  {31'h0, done},       32'h0);
            tick();
        end
        start = 1'b0;
        bus(1'b1, 1'b1, 32'h0000_0055);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("c_done_end", {31'h0, done}, 32'h1);
        chk("c_instr",    instr,         32'h0000_0055);

        // Back-to-back: start accepted in the done cycle.
        pc = 32'h0000_3000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("d_addr",  ireq.addr,           32'h0000_3000);
        chk("d_valid", {31'h0, ireq.valid}, 32'h1);
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b1, 32'h0000_0077);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("d_done",  {31'h0, done}, 32'h1);
        chk("d_instr", instr,         32'h0000_0077);

        // Flush in DATA, data arrives two cycles later and is dropped.
        pc = 32'h0000_4000; start = 1'b1;
        tick();
        start = 1'b0;
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("e_busy_drain", {31'h0, busy}, 32'h1);
        tick();
        bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("e_busy_pre", {31'h0, busy}, 32'h1);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("e_busy_off", {31'h0, busy}, 32'h0);
        chk("e_nodone",   {31'h0, done}, 32'h0);
        chk("e_instr",    instr,         32'h0000_0077);

        // Flush in ADDR keeps the request until addr_ok, then drains.
        pc = 32'h0000_5000; start = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("f_held",  {31'h0, ireq.valid}, 32'h1);
        chk("f_haddr", ireq.addr,           32'h0000_5000);
        bus(1'b1, 1'b0, 32'h0);
        tick();
        chk("f_drain_valid", {31'h0, ireq.valid}, 32'h0);
        chk("f_drain_busy",  {31'h0, busy},       32'h1);
        bus(1'b0, 1'b1, 32'h0000_0099);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("f_idle",   {31'h0, busy}, 32'h0);
        chk("f_nodone", {31'h0, done}, 32'h0);
        chk("f_instr",  instr,         32'h0000_0077);

        // Flush with start in IDLE, and stray bus handshakes in IDLE.
        pc = 32'h0000_6000; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("g_busy",  {31'h0, busy},       32'h0);
        chk("g_valid", {31'h0, ireq.valid}, 32'h0);
        bus(1'b1, 1'b1, 32'h0000_1234);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("g_nodone", {31'h0, done}, 32'h0);
        chk("g_instr",  instr,         32'h0000_0077);

        // Misaligned PC.
        pc = 32'hBFC0_0002; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("h_valid", {31'h0, ireq.valid}, 32'h0);
        chk("h_done",  {31'h0, done},       32'h1);
        chk("h_fault", {31'h0, fault},      32'h1);
        chk("h_instr", instr,               RI);
        chk("h_busy",  {31'h0, busy},       32'h0);
        tick();
        chk("h_fault_clr", {31'h0, fault}, 32'h0);
`else
        chk("h_valid", {31'h0, ireq.valid}, 32'h1);
        chk("h_addr",  ireq.addr,           32'hBFC0_0002);
        chk("h_nodone", {31'h0, done},      32'h0);
        bus(1'b1, 1'b1, 32'h0000_00AB);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("h_done",  {31'h0, done},  32'h1);
        chk("h_fault", {31'h0, fault}, 32'h0);
        chk("h_instr", instr,          32'h0000_00AB);
`endif

        // Reset during DATA; late data_ok after release is ignored.
        pc = 32'h0000_7000; start = 1'b1;
        tick();
        start = 1'b0;
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("i_in_data", {31'h0, busy}, 32'h1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("i_busy",  {31'h0, busy}, 32'h0);
        chk("i_instr", instr,         RI);
        bus(1'b0, 1'b1, 32'h0000_0066);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        chk("i_nodone", {31'h0, done}, 32'h0);
        chk("i_instr2", instr,         RI);
        chk("i_idle",   {31'h0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
